// File: rtl/ex_mult_div_unit.sv
// Iterative EX-stage multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with sign fix-up and the architectural HI/LO registers.
module ex_mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start_EX,
    input  logic [2:0]       MD_Op_EX,
    input  logic [WIDTH-1:0] ALU_Data_1_EX,
    input  logic [WIDTH-1:0] ALU_Data_2_EX,
    input  logic             Flush_EX,
    output logic [WIDTH-1:0] HI_EX,
    output logic [WIDTH-1:0] LO_EX,
    output logic             Busy_EX,
    output logic             Done_EX
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(ITER - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opnd_r, orig_a_r, hi_r, lo_r;
    logic             is_div_r, neg_a_r, neg_b_r, div_zero_r, busy_r, done_r;

    logic             start_div_s, start_signed_s, neg_a_s, neg_b_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, step_hi_s, step_lo_s, res_hi_s, res_lo_s;
    logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] prod_fix_s;

    // Operand decode at issue: sign flags and magnitudes for the signed ops
    always_comb begin
        start_div_s    = (MD_Op_EX == OP_DIV) || (MD_Op_EX == OP_DIVU);
        start_signed_s = (MD_Op_EX == OP_MULT) || (MD_Op_EX == OP_DIV);
        neg_a_s        = start_signed_s & ALU_Data_1_EX[WIDTH-1];
        neg_b_s        = start_signed_s & ALU_Data_2_EX[WIDTH-1];
        if (neg_a_s) begin
            a_mag_s = neg_w(ALU_Data_1_EX);
        end else begin
            a_mag_s = ALU_Data_1_EX;
        end
        if (neg_b_s) begin
            b_mag_s = neg_w(ALU_Data_2_EX);
        end else begin
            b_mag_s = ALU_Data_2_EX;
        end
    end

    // One iteration: {acc_hi,acc_lo} is the product/multiplier pair or remainder/dividend pair
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!div_diff_s[WIDTH]) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            {step_hi_s, step_lo_s} = {mul_sum_s, acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction; divide-by-zero bypasses it and reports the raw dividend
    always_comb begin
        prod_fix_s = (neg_a_r ^ neg_b_r) ? neg_2w({acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
        if (is_div_r) begin
            if (div_zero_r) begin
                res_hi_s = orig_a_r;
                res_lo_s = ONES_W;
            end else begin
                res_hi_s = neg_a_r ? neg_w(acc_hi_r) : acc_hi_r;
                res_lo_s = (neg_a_r ^ neg_b_r) ? neg_w(acc_lo_r) : acc_lo_r;
            end
        end else begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            acc_hi_r   <= ZERO_W;
            acc_lo_r   <= ZERO_W;
            opnd_r     <= ZERO_W;
            orig_a_r   <= ZERO_W;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            is_div_r   <= 1'b0;
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (Flush_EX) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (Start_EX) begin
                        case (MD_Op_EX)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_r   <= start_div_s;
                                neg_a_r    <= neg_a_s;
                                neg_b_r    <= neg_b_s;
                                div_zero_r <= start_div_s && (ALU_Data_2_EX == ZERO_W);
                                orig_a_r   <= ALU_Data_1_EX;
                                acc_hi_r   <= ZERO_W;
                                acc_lo_r   <= start_div_s ? a_mag_s : b_mag_s;
                                opnd_r     <= start_div_s ? b_mag_s : a_mag_s;
                                cnt_r      <= {CW{1'b0}};
                                state_r    <= RUN;
                                busy_r     <= 1'b1;
                            end
                            OP_MTHI: hi_r <= ALU_Data_1_EX;
                            OP_MTLO: lo_r <= ALU_Data_1_EX;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    hi_r    <= res_hi_s;
                    lo_r    <= res_lo_s;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign HI_EX   = hi_r;
    assign LO_EX   = lo_r;
    assign Busy_EX = busy_r;
    assign Done_EX = done_r;

endmodule

// File: tb/tb_ex_mult_div_unit.sv
// Directed bench for ex_mult_div_unit: a scoreboard queue of expected HI/LO pairs is
// filled at issue and drained when Done_EX pulses; cycle-exact Busy/Done timing is checked.
module tb_ex_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start_EX = 1'b0;
    logic [2:0]  MD_Op_EX = 3'd0;
    logic [31:0] ALU_Data_1_EX = 32'h0;
    logic [31:0] ALU_Data_2_EX = 32'h0;
    logic        Flush_EX = 1'b0;
    logic [31:0] HI_EX, LO_EX;
    logic        Busy_EX, Done_EX;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    ex_mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start_EX(Start_EX), .MD_Op_EX(MD_Op_EX),
        .ALU_Data_1_EX(ALU_Data_1_EX), .ALU_Data_2_EX(ALU_Data_2_EX), .Flush_EX(Flush_EX),
        .HI_EX(HI_EX), .LO_EX(LO_EX), .Busy_EX(Busy_EX), .Done_EX(Done_EX)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Reference results built from the language's own arithmetic operators
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     sq, sr;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            3'd2: return {32'h0, a} * {32'h0, b};
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            3'd4: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // inj_kind: 0 none, 1 MTLO issued at inj_cyc, 2 flush at inj_cyc
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int inj_cyc, input int inj_kind);
        logic [63:0] got;
        logic        exp_busy, exp_done;
        if (inj_kind != 2) sb_q.push_back(exp);
        Start_EX = 1'b1; MD_Op_EX = op; ALU_Data_1_EX = a; ALU_Data_2_EX = b;
        chk({tag, " busy"}, 0, {63'h0, Busy_EX}, 64'h0);
        tick();
        Start_EX = 1'b0; MD_Op_EX = 3'd0;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            if (cyc == inj_cyc && inj_kind == 1) begin
                Start_EX = 1'b1; MD_Op_EX = 3'd6; ALU_Data_1_EX = 32'hDEADBEEF;
            end
            if (cyc == inj_cyc && inj_kind == 2) Flush_EX = 1'b1;
            exp_busy = (inj_kind == 2) ? (cyc <= inj_cyc) : (cyc <= 34);
            exp_done = (inj_kind != 2) && (cyc == 34);
            chk({tag, " busy"}, cyc, {63'h0, Busy_EX}, {63'h0, exp_busy});
            chk({tag, " done"}, cyc, {63'h0, Done_EX}, {63'h0, exp_done});
            if (Done_EX && sb_q.size() > 0) begin
                got  = sb_q.pop_front();
                hi_m = got[63:32];
                lo_m = got[31:0];
            end
            chk({tag, " hilo"}, cyc, {HI_EX, LO_EX}, {hi_m, lo_m});
            tick();
            Start_EX = 1'b0; MD_Op_EX = 3'd0; Flush_EX = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (2) tick();
        chk("reset hilo", 0, {HI_EX, LO_EX}, 64'h0);
        chk("reset busy_done", 0, {62'h0, Busy_EX, Done_EX}, 64'h0);
        Reset_n = 1'b1;
        tick();

        do_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 0, 0);
        do_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, 0);
        do_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 0, 0);
        do_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, 0);
        do_op("divu_zero", 3'd4, 32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF, 0, 0);

        Start_EX = 1'b1; MD_Op_EX = 3'd5; ALU_Data_1_EX = 32'hA5A5A5A5;
        tick();
        Start_EX = 1'b0; MD_Op_EX = 3'd0;
        hi_m = 32'hA5A5A5A5;
        chk("mthi", 1, {HI_EX, LO_EX}, {hi_m, lo_m});
        chk("mthi busy", 1, {63'h0, Busy_EX}, 64'h0);

        Start_EX = 1'b1; MD_Op_EX = 3'd6; ALU_Data_1_EX = 32'h5A5A0F0F;
        tick();
        Start_EX = 1'b0; MD_Op_EX = 3'd0;
        lo_m = 32'h5A5A0F0F;
        chk("mtlo", 1, {HI_EX, LO_EX}, {hi_m, lo_m});

        do_op("mult_mtlo_ign", 3'd1, 32'h00012345, 32'hFFFF0000,
              model(3'd1, 32'h00012345, 32'hFFFF0000), 10, 1);
        do_op("flush_run", 3'd4, 32'h0000FFFF, 32'h00000003, 64'h0, 20, 2);
        do_op("flush_fix", 3'd1, 32'h12345678, 32'h9ABCDEF0, 64'h0, 33, 2);
        do_op("div_zero_s", 3'd3, 32'h80000005, 32'h00000000,
              model(3'd3, 32'h80000005, 32'h00000000), 0, 0);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 2 == 1) rb = rb >> 27;
            do_op("rand", rop, ra, rb, model(rop, ra, rb), 0, 0);
        end

        // Asynchronous reset in the middle of a running multiply
        Start_EX = 1'b1; MD_Op_EX = 3'd2; ALU_Data_1_EX = 32'hCAFEF00D; ALU_Data_2_EX = 32'h12345678;
        tick();
        Start_EX = 1'b0; MD_Op_EX = 3'd0;
        repeat (9) tick();
        chk("pre_rst busy", 10, {63'h0, Busy_EX}, 64'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst hilo", 10, {HI_EX, LO_EX}, 64'h0);
        chk("async_rst busy_done", 10, {62'h0, Busy_EX, Done_EX}, 64'h0);
        hi_m = 32'h0; lo_m = 32'h0;
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        chk("post_rst busy", 0, {63'h0, Busy_EX}, 64'h0);
        chk("sb_empty", 0, 64'(sb_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
